// File: rtl/ram_arbiter.sv
// ram_arbiter
//
// Shares the single program/data RAM between the CPU datapath and the
// front-panel/serial programming port. Each access takes three cycles:
// an IDLE cycle in which one request is picked, a GNT cycle that drives the
// RAM, and an ACK cycle that returns read data and pulses the master's ack.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata        CPU access request and command
//   cpu_ack, cpu_rdata           CPU completion pulse and read data
//   prg_req/we/addr/wdata        programming-port request and command
//   prg_ack, prg_rdata           programming-port completion and read data
//   ram_addr, ram_we, ram_wdata  RAM control (this block is the only driver)
//   ram_rdata                    synchronous RAM read data
//   busy                         high whenever the arbiter is not in IDLE
//
// Build option
//   ARB_ROUND_ROBIN_EN  defined: ties go to the master not served last.
//                       undefined: the programming port always wins ties.

module ram_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          prg_req,
    input  logic          prg_we,
    input  logic [AW-1:0] prg_addr,
    input  logic [DW-1:0] prg_wdata,
    output logic          prg_ack,
    output logic [DW-1:0] prg_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] GNT_CPU = 3'd1;
    localparam logic [2:0] ACK_CPU = 3'd2;
    localparam logic [2:0] GNT_PRG = 3'd3;
    localparam logic [2:0] ACK_PRG = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          last_prg;
    logic          tie_prg;
    logic          pick_prg;
    logic          any_req;

    // Tie-break rule. In the fixed-priority build last_prg is still kept up
    // to date but cannot change the outcome.
`ifdef ARB_ROUND_ROBIN_EN
    assign tie_prg = ~last_prg;
`else
    assign tie_prg = last_prg | 1'b1;
`endif

    assign any_req  = cpu_req | prg_req;
    assign pick_prg = prg_req & (~cpu_req | tie_prg);

    // Next-state: IDLE picks a winner, GNT always goes to ACK, ACK back to IDLE.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = any_req ? (pick_prg ? GNT_PRG : GNT_CPU) : IDLE;
            GNT_CPU: state_next = ACK_CPU;
            GNT_PRG: state_next = ACK_PRG;
            default: state_next = IDLE;
        endcase
    end

    // The winner's command is captured only on the IDLE->GNT edge, so the
    // masters may change their inputs freely during GNT and ACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            last_prg  <= 1'b1;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                cmd_we    <= pick_prg ? prg_we    : cpu_we;
                cmd_addr  <= pick_prg ? prg_addr  : cpu_addr;
                cmd_wdata <= pick_prg ? prg_wdata : cpu_wdata;
                last_prg  <= pick_prg;
            end
        end
    end

    // Address and data always come from the command register; only the
    // strobe and acks depend on state. Gating with rst keeps an abandoned
    // access from writing the RAM or acking its master.
    assign ram_addr  = cmd_addr;
    assign ram_wdata = cmd_wdata;
    assign ram_we    = ~rst & cmd_we & (state == GNT_CPU || state == GNT_PRG);
    assign cpu_ack   = ~rst & (state == ACK_CPU);
    assign prg_ack   = ~rst & (state == ACK_PRG);
    assign cpu_rdata = (cpu_ack & ~cmd_we) ? ram_rdata : '0;
    assign prg_rdata = (prg_ack & ~cmd_we) ? ram_rdata : '0;
    assign busy      = (state != IDLE);

endmodule
